posit_add_arbiter_es2: RTL
==========================

# posit_add_arbiter_es2

Shares one fixed-latency, non-stallable ES2 serialized posit adder pipeline among `NREQ` requesters. Each cycle, a round-robin arbiter issues at most one operand pair into the adder and tags it with the requester index. A tag pipeline tracks in-flight operations. Results are collected in an output FIFO with valid/ready backpressure, and credit-based occupancy accounting guarantees the FIFO can never overflow.

## Interface
- `NREQ`, default 4: number of requesters, range 2..8.
- `LATENCY`, default 8: cycles from adder `start` to adder `done`.
- `FIFO_DEPTH`, default 16: result FIFO entries; power of two; at least 2.
- `W`, default `POSIT_SERIALIZED_WIDTH_ES2` (38): serialized posit width.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req_valid`  in  NREQ: per-requester operand pair valid.
- `req_ready`  out  NREQ: one-hot grant; the transfer happens when `req_valid[i] & req_ready[i]`.
- `req_in1`, `req_in2`  in  NREQ*W each: operands; requester i occupies slice `[i*W +: W]`.
- `add_in1`, `add_in2`  out  W: operands driven to the adder.
- `add_start`  out  1: adder start strobe.
- `add_result`  in  W: adder result.
- `add_done`  in  1: adder done strobe.
- `res_valid`  out  1: FIFO head valid.
- `res_ready`  in  1: consumer accepts the FIFO head.
- `res_data`  out  W: result payload.
- `res_id`  out  `$clog2(NREQ)`: index of the requester that issued the result.
- `busy`  out  1: high when occupancy is nonzero.
- `err`  out  1: sticky tag/done mismatch flag.

## Operation
- **Occupancy `occ`** (0..FIFO_DEPTH) = operations granted but not yet popped from the FIFO.
  - +1 on a grant; −1 on a pop (`res_valid & res_ready`).
  - A grant and a pop in the same cycle leave `occ` unchanged.
- **Issue eligibility:** `can_issue = (occ < FIFO_DEPTH) | pop`.
  - A pop in the same cycle frees a slot, so full-throughput operation continues at `occ == FIFO_DEPTH`.
- **Arbitration:** round-robin pointer `rr`, reset 0.
  - Search starts at `rr`; the first i (mod NREQ) with `req_valid[i]` wins.
  - On a grant to i, `rr` becomes (i+1) mod NREQ. Without a grant, `rr` holds.
- **Grant signals:**
  - `req_ready` is combinational from `req_valid`, `rr` and `can_issue`.
  - Requesters must not make `req_valid` depend on `req_ready`.
  - A requester holding valid keeps its operands stable until it is granted.
- **Adder drive (combinational):**
  - `add_start` = any grant.
  - `add_in1`/`add_in2` = the winner's operands.
  - When there is no grant, `add_in1`/`add_in2` are 0.
- **Tag pipe:** LATENCY-stage shift register of {valid, id}; stage 0 is loaded with {grant, winner id}.
- **On `add_done` with a valid tag-pipe output:** push {id, `add_result`} into the FIFO.
- **On `add_done` with an invalid tag-pipe output:** drop the result silently. This drains operations issued before a reset; `err` is not set.
- **On a valid tag-pipe output without `add_done`:** set `err` (sticky until `rst`); push nothing; decrement `occ` by 1 to release the credit.
- **FIFO:** registered storage; `res_data`/`res_id` come from the head entry.
  - A push and a pop in the same cycle are both performed.
  - The FIFO never receives a push while full; this is guaranteed by `occ`.

## Timing
- **Reset values:**
  - `req_ready`=0, `add_start`=0, `add_in1`/`add_in2`=0.
  - `res_valid`=0, `res_data`=0, `res_id`=0, `busy`=0, `err`=0.
  - `occ`=0, `rr`=0, tag pipe cleared, FIFO empty.
- **During `rst`:** no grants are issued.
- **Issue-to-result latency:** a grant in cycle T gives `add_done` in T+LATENCY, the FIFO write at the end of that cycle, and `res_valid` in T+LATENCY+1. The default is 9 cycles.
- **Throughput:** 1 issue per cycle when `res_ready` is held high.
- **Reset mid-operation:**
  - Adder results still in flight arrive with invalid tags and are dropped.
  - Nothing from before the reset appears on `res_*`.
- **Backpressure:**
  - With `res_ready`=0, at most FIFO_DEPTH grants occur, then `req_ready` stays 0.
  - Issue resumes in the same cycle that `res_ready` pops an entry.

## Test plan
- **Single issue:** `req_valid[2]`=1 for one cycle with in1=in2=1.0 (sgn 0, scale 0, fraction 0, inf 0, zero 0) → `add_start` in cycle 0; in cycle 9, `res_valid`=1, `res_id`=2 and `res_data` scale=1 (2.0); `busy` is 0 after the pop.
- **Round-robin order:** all four `req_valid` held high for 8 cycles with `res_ready`=1 → grant order 0,1,2,3,0,1,2,3; results appear in cycles 9..16 with ids in the same order.
- **Backpressure:** FIFO_DEPTH=16, requester 0 continuously valid, `res_ready`=0 → exactly 16 grants, `req_ready` stays 0 afterwards; raise `res_ready` → one grant per pop, no data lost or duplicated.
- **Full boundary:** at `occ`=16, a pop and a pending request in the same cycle → grant issued, `occ` stays 16.
- **Reset mid-flight:** issue 5 operations, assert `rst` for 1 cycle 3 cycles later → no `res_valid` for the pre-reset operations, `err`=0; the first post-reset operation returns in 9 cycles.
- **Mismatch:** force `add_done` low at the expected cycle → `err`=1 and stays 1, `occ` is decremented, and subsequent operations still complete.

Source files
------------

// File: rtl/posit_add_arbiter_es2.sv
// Shared-width constant for the serialized ES2 posit format used by the adder.
// Latency: n/a (constants only).
// Backpressure: n/a.
package posit_es2_pkg;
  localparam int POSIT_SERIALIZED_WIDTH_ES2 = 38;
endpackage

// Small synchronous FIFO holding {id, result} entries for the arbiter.
// Latency: a push is visible at the head on the cycle after it is written.
// Backpressure: head_vld/pop_rdy on the read side; the writer guarantees no push while full.
module posit_add_arbiter_es2_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  output logic             head_vld,
  output logic [WIDTH-1:0] head_dat,
  input  logic             pop_rdy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             pop;

  assign head_vld = (count != '0);
  assign pop      = head_vld & pop_rdy;
  // Empty FIFO presents zero so the outputs have a defined reset value.
  assign head_dat = head_vld ? mem[rd_ptr] : '0;

  // Storage write; contents need no reset because count gates the head.
  always_ff @(posedge clk) begin
    if (push_vld) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // Pointer and fill-level bookkeeping; push and pop may coincide.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_vld) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CW'(push_vld) - CW'(pop);
    end
  end
endmodule

// Round-robin front end sharing one fixed-latency ES2 posit adder among NREQ requesters.
// Latency: grant in cycle T -> add_done in T+LATENCY -> res_valid in T+LATENCY+1; grants are combinational.
// Backpressure: res_valid/res_ready on results; grants stop while FIFO_DEPTH credits are outstanding.
module posit_add_arbiter_es2 #(
  parameter int NREQ       = 4,
  parameter int LATENCY    = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int W          = posit_es2_pkg::POSIT_SERIALIZED_WIDTH_ES2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*W-1:0]       req_in1,
  input  logic [NREQ*W-1:0]       req_in2,
  output logic [W-1:0]            add_in1,
  output logic [W-1:0]            add_in2,
  output logic                    add_start,
  input  logic [W-1:0]            add_result,
  input  logic                    add_done,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [W-1:0]            res_data,
  output logic [$clog2(NREQ)-1:0] res_id,
  output logic                    busy,
  output logic                    err
);
  localparam int IDW  = $clog2(NREQ);
  localparam int OCCW = $clog2(FIFO_DEPTH + 1);
  localparam logic [OCCW-1:0] OCC_FULL = OCCW'(FIFO_DEPTH);
  localparam logic [IDW-1:0]  ID_LAST  = IDW'(NREQ - 1);

  // Arbitration state and decisions
  logic [IDW-1:0]  rr;
  logic [IDW-1:0]  win_id;
  logic [IDW-1:0]  cand;
  logic            found;
  logic            grant_vld;
  logic            can_issue;
  logic            pop;

  // Credit counter: operations granted but not yet consumed
  logic [OCCW-1:0] occ;

  // Tag pipe mirroring the adder pipeline
  logic [LATENCY-1:0]          tag_vld;
  logic [LATENCY-1:0][IDW-1:0] tag_id;
  logic                        tag_out_vld;
  logic [IDW-1:0]              tag_out_id;
  logic                        push_vld;
  logic                        miss;

  assign pop = res_valid & res_ready;
  // A same-cycle pop frees a slot, keeping full throughput at occ == FIFO_DEPTH.
  assign can_issue = ~rst & ((occ < OCC_FULL) | pop);

  // Rotating priority search starting at rr; first valid requester wins.
  always_comb begin
    win_id = '0;
    found  = 1'b0;
    cand   = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IDW'((int'(rr) + k) % NREQ);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        win_id = cand;
      end
    end
  end

  assign grant_vld = found & can_issue;

  // One-hot grant back to the winning requester.
  always_comb begin
    req_ready = '0;
    if (grant_vld) begin
      req_ready[win_id] = 1'b1;
    end
  end

  assign add_start = grant_vld;
  assign add_in1   = grant_vld ? req_in1[int'(win_id)*W +: W] : '0;
  assign add_in2   = grant_vld ? req_in2[int'(win_id)*W +: W] : '0;

  // Shift {valid, id} alongside the adder so each result can be re-tagged on exit.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld <= '0;
      tag_id  <= '0;
    end else begin
      tag_vld[0] <= grant_vld;
      tag_id[0]  <= win_id;
      for (int s = 1; s < LATENCY; s++) begin
        tag_vld[s] <= tag_vld[s-1];
        tag_id[s]  <= tag_id[s-1];
      end
    end
  end

  assign tag_out_vld = tag_vld[LATENCY-1];
  assign tag_out_id  = tag_id[LATENCY-1];
  // Untagged done pulses belong to operations issued before a reset and are dropped.
  assign push_vld    = add_done & tag_out_vld;
  // A tagged slot with no done pulse means the adder lost an operation.
  assign miss        = tag_out_vld & ~add_done;

  // Credit accounting: +grant, -pop, and -miss to return the credit of a lost operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ <= '0;
    end else begin
      occ <= occ + OCCW'(grant_vld) - OCCW'(pop) - OCCW'(miss);
    end
  end

  // Round-robin pointer moves past the winner only when a grant happens.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr <= '0;
    end else if (grant_vld) begin
      rr <= (win_id == ID_LAST) ? '0 : win_id + 1'b1;
    end
  end

  // Sticky tag/done mismatch flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (miss) begin
      err <= 1'b1;
    end
  end

  assign busy = (occ != '0);

  posit_add_arbiter_es2_fifo #(
    .WIDTH (IDW + W),
    .DEPTH (FIFO_DEPTH)
  ) u_res_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_vld (push_vld),
    .push_dat ({tag_out_id, add_result}),
    .head_vld (res_valid),
    .head_dat ({res_id, res_data}),
    .pop_rdy  (res_ready)
  );
endmodule
